// File: rtl/aes_pkg.sv
// Shared AES definitions: round/width constants, key-schedule state type and the round-constant table.
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    typedef logic [31:0] aes_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2
    } ks_state_t;

    // Only rounds 1..10 are meaningful; other indices never reach the G function.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_g_word.sv
// Key-expansion G function: RotWord, per-byte SubWord, then round-constant XOR on the top byte.
module aes_g_word
    import aes_pkg::*;
(
    input  aes_word_t  w,
    input  logic [3:0] rnd,
    output aes_word_t  g
);

    aes_word_t rot;
    aes_word_t sub;

    assign rot = {w[23:0], w[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*i +: 8]),
            .s (sub[8*i +: 8])
        );
    end

    assign g = sub ^ {rcon(rnd), 24'h000000};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the field inverse, and conveniently maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key schedule: expands the cipher key forward to K10, then walks back to K0 one key per handshake.
module aes_inv_key_sched #(
    parameter int NR    = aes_pkg::NR,
    parameter int KEY_W = aes_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_round,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy
);
    import aes_pkg::*;

    if (NR != 10 || KEY_W != 128) begin : g_bad_param
        $error("aes_inv_key_sched supports only AES-128 (NR=10, KEY_W=128)");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    ks_state_t        state;
    logic [KEY_W-1:0] key_q;
    logic [3:0]       rnd;

    aes_word_t a, b, c, d;
    aes_word_t d_rev;
    aes_word_t g_in;
    aes_word_t g_out;
    logic [KEY_W-1:0] fwd_key;
    logic [KEY_W-1:0] rev_key;

    assign {a, b, c, d} = key_q;
    assign d_rev        = d ^ c;

    // One shared G: the reverse step needs G of the recovered last word, the forward step G of w3.
    assign g_in = (state == EMIT) ? d_rev : d;

    aes_g_word u_g (
        .w   (g_in),
        .rnd (rnd),
        .g   (g_out)
    );

    always_comb begin
        fwd_key[127:96] = a ^ g_out;
        fwd_key[95:64]  = fwd_key[127:96] ^ b;
        fwd_key[63:32]  = fwd_key[95:64] ^ c;
        fwd_key[31:0]   = fwd_key[63:32] ^ d;
        rev_key         = {a ^ g_out, b ^ a, c ^ b, d_rev};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            key_q <= '0;
            rnd   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        key_q <= key_in;
                        rnd   <= 4'd1;
                        state <= FWD;
                    end
                end
                FWD: begin
                    key_q <= fwd_key;
                    if (rnd == LAST_RND) state <= EMIT;
                    else                 rnd   <= rnd + 4'd1;
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (rnd != 4'd0) begin
                            key_q <= rev_key;
                            rnd   <= rnd - 4'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rk_valid  = (state == EMIT);
    assign rk_out    = rk_valid ? key_q : '0;
    assign rk_round  = rnd;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed/randomized bench for the inverse key schedule against a FIPS-197 style expansion model.
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q[$];
    logic [127:0] cap [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    aes_inv_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        row = SBOX_ROWS[x[7:4]];
        return row[127 - 8*x[3:0] -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Textbook forward expansion into 44 words; expected queue holds K10 first, K0 last.
    function automatic void build_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        exp_q.delete();
        for (int r = 10; r >= 0; r--) exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns at the negedge where rk_valid first appears.
    task automatic load_key(input logic [127:0] k, input bit pulse);
        int cnt;
        build_model(k);
        cnt = 0;
        while (!key_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("key_ready_before_load", 128'(key_ready), 128'd1);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        chk("busy_in_fwd", 128'(busy), 128'd1);
        chk("key_ready_in_fwd", 128'(key_ready), 128'd0);
        cnt = 0;
        while (!rk_valid && cnt < 50) begin
            if (pulse) begin
                key_valid = 1'($urandom_range(0, 1));
                key_in    = rand_key();
            end
            @(negedge clk);
            cnt++;
        end
        key_valid = 1'b0;
        chk("latency", 128'(cnt), 128'd10);
    endtask

    // Consume round keys; random_ready stalls randomly, stop_at >= 0 returns before that round is taken.
    task automatic drain(input bit random_ready, input bit pulse, input int stop_at);
        int idx;
        int cyc;
        idx = 10;
        cyc = 0;
        while (idx >= 0 && cyc < 300) begin
            if (idx == stop_at) begin
                rk_ready = 1'b0;
                return;
            end
            rk_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse) begin
                key_valid = 1'($urandom_range(0, 1));
                key_in    = rand_key();
            end
            chk("rk_valid", 128'(rk_valid), 128'd1);
            chk("rk_out", rk_out, exp_q[0]);
            chk("rk_round", 128'(rk_round), 128'(idx));
            chk("key_ready_emit", 128'(key_ready), 128'd0);
            if (rk_ready) begin
                cap[idx] = rk_out;
                void'(exp_q.pop_front());
                idx--;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        rk_ready  = 1'b0;
        key_valid = 1'b0;
        chk("all_keys_taken", 128'(idx == -1), 128'd1);
        if (!random_ready) chk("cycles_ready_held", 128'(cyc), 128'd11);
        chk("rk_valid_after_last", 128'(rk_valid), 128'd0);
        chk("key_ready_after_last", 128'(key_ready), 128'd1);
        chk("rk_out_idle", rk_out, 128'd0);
        chk("busy_idle", 128'(busy), 128'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_key_ready", 128'(key_ready), 128'd1);
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("rst_rk_out", rk_out, 128'd0);
        chk("rst_rk_round", 128'(rk_round), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rk_valid", 128'(rk_valid), 128'd0);

        // FIPS-197 key, consumer always ready
        load_key(FIPS_KEY, 1'b0);
        drain(1'b0, 1'b0, -1);
        chk("fips_k10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_k1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_k0", cap[0], FIPS_KEY);

        // Same key under random backpressure
        load_key(FIPS_KEY, 1'b0);
        drain(1'b1, 1'b0, -1);
        chk("bp_k10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("bp_k0", cap[0], FIPS_KEY);

        // All-zero key
        load_key(128'd0, 1'b0);
        drain(1'b0, 1'b0, -1);
        chk("zero_k10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        chk("zero_k0", cap[0], 128'd0);

        // Random key with stray key_valid pulses in FWD and EMIT
        load_key(rand_key(), 1'b1);
        drain(1'b1, 1'b1, -1);

        // Reset in the middle of emission
        load_key(rand_key(), 1'b0);
        drain(1'b0, 1'b0, 6);
        rst_n = 1'b0;
        #1;
        chk("midrst_rk_valid", 128'(rk_valid), 128'd0);
        chk("midrst_rk_out", rk_out, 128'd0);
        chk("midrst_rk_round", 128'(rk_round), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_key_ready", 128'(key_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_rk_valid", 128'(rk_valid), 128'd0);
        load_key(rand_key(), 1'b0);
        drain(1'b0, 1'b0, -1);

        // Back-to-back keys
        load_key(FIPS_KEY, 1'b0);
        drain(1'b0, 1'b0, -1);
        load_key(rand_key(), 1'b0);
        drain(1'b1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
